// File: rtl/serdes_rx_aligner.sv
// serdes_rx_aligner
// Receive-side 8b/10b word aligner. Shifts in one serial bit per enabled
// clock, hunts for the K28.5 comma to find the symbol boundary, then emits
// boundary-aligned 10-bit symbols with a single-cycle valid strobe and a
// lock indication for the downstream decoder.
//
// Output handshake: sym_valid is a one-clk pulse with no back-pressure.
// sym_out is valid whenever sym_valid is high and otherwise holds the last
// emitted symbol. comma_det only ever pulses together with sym_valid.
//
// Bit order: the first received bit lands in sym_out[0] (bit a).
// The next-window value win = {rx_in, sr[9:1]} is used for every decision
// on an enabled edge, so a symbol whose last bit arrives at edge N is on
// sym_out with sym_valid high in the cycle right after edge N.

module serdes_rx_aligner #(
    parameter logic [9:0] COMMA_NEG   = 10'h17C,  // K28.5 RD-, bit0 = first received
    parameter logic [9:0] COMMA_POS   = 10'h283,  // K28.5 RD+, bit0 = first received
    parameter int         LOCK_COMMAS = 2,        // aligned commas needed to lock (1..7)
    parameter int         LOSS_LIMIT  = 2         // misaligned commas that drop lock (1..7)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       rx_in,
    output logic [9:0] sym_out,
    output logic       sym_valid,
    output logic       comma_det,
    output logic       locked,
    output logic [1:0] state_o
);

    // Debug-visible state encoding: 0 HUNT, 1 CHECK, 2 LOCKED.
    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [2:0] LOCK_N = LOCK_COMMAS[2:0];
    localparam logic [2:0] LOSS_N = LOSS_LIMIT[2:0];

    state_t     state_q;
    logic [9:0] sr_q;
    logic [3:0] bit_cnt_q;
    logic [2:0] good_cnt_q;
    logic [2:0] bad_cnt_q;
    logic [9:0] sym_out_q;
    logic       sym_valid_q;
    logic       comma_det_q;
    logic       locked_q;

    logic [9:0] win;
    logic       is_comma;
    logic       boundary;
    logic [3:0] bit_cnt_d;
    logic [2:0] good_cnt_d;
    logic [2:0] bad_cnt_d;

    // The window as it will look after this edge's bit is shifted in.
    assign win       = {rx_in, sr_q[9:1]};
    assign is_comma  = (win == COMMA_NEG) || (win == COMMA_POS);
    assign boundary  = (bit_cnt_q == 4'd9);

    // Free-running symbol phase wraps 9 -> 0; realign overrides it to 0.
    assign bit_cnt_d  = boundary ? 4'd0 : (bit_cnt_q + 4'd1);
    assign good_cnt_d = good_cnt_q + 3'd1;
    assign bad_cnt_d  = bad_cnt_q + 3'd1;

    // Shift register, symbol phase, alignment FSM and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_HUNT;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            sym_out_q   <= '0;
            sym_valid_q <= 1'b0;
            comma_det_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            // Strobes are single-cycle; they drop on every edge unless re-fired.
            sym_valid_q <= 1'b0;
            comma_det_q <= 1'b0;

            if (enable) begin
                sr_q      <= win;
                bit_cnt_q <= bit_cnt_d;

                unique case (state_q)
                    ST_HUNT: begin
                        // First comma anywhere defines the boundary.
                        if (is_comma) begin
                            sym_out_q   <= win;
                            sym_valid_q <= 1'b1;
                            comma_det_q <= 1'b1;
                            bit_cnt_q   <= 4'd0;
                            good_cnt_q  <= 3'd1;
                            bad_cnt_q   <= 3'd0;
                            if (LOCK_N == 3'd1) begin
                                state_q  <= ST_LOCKED;
                                locked_q <= 1'b1;
                            end else begin
                                state_q  <= ST_CHECK;
                            end
                        end
                    end

                    ST_CHECK: begin
                        if (is_comma && !boundary) begin
                            // Comma off the tentative boundary: trust the new one.
                            sym_out_q   <= win;
                            sym_valid_q <= 1'b1;
                            comma_det_q <= 1'b1;
                            bit_cnt_q   <= 4'd0;
                            good_cnt_q  <= 3'd1;
                        end else if (boundary) begin
                            sym_out_q   <= win;
                            sym_valid_q <= 1'b1;
                            if (is_comma) begin
                                comma_det_q <= 1'b1;
                                good_cnt_q  <= good_cnt_d;
                                if (good_cnt_d >= LOCK_N) begin
                                    state_q   <= ST_LOCKED;
                                    locked_q  <= 1'b1;
                                    bad_cnt_q <= 3'd0;
                                end
                            end
                        end
                    end

                    ST_LOCKED: begin
                        if (is_comma && !boundary) begin
                            // Misaligned comma: count it, no symbol is emitted.
                            if (bad_cnt_d == LOSS_N) begin
                                state_q    <= ST_HUNT;
                                locked_q   <= 1'b0;
                                bad_cnt_q  <= 3'd0;
                                good_cnt_q <= 3'd0;
                            end else begin
                                bad_cnt_q  <= bad_cnt_d;
                            end
                        end else if (boundary) begin
                            sym_out_q   <= win;
                            sym_valid_q <= 1'b1;
                            if (is_comma) begin
                                comma_det_q <= 1'b1;
                                bad_cnt_q   <= 3'd0;
                            end
                        end
                    end

                    default: begin
                        state_q  <= ST_HUNT;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sym_out   = sym_out_q;
    assign sym_valid = sym_valid_q;
    assign comma_det = comma_det_q;
    assign locked    = locked_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_serdes_rx_aligner.sv
// tb_serdes_rx_aligner
// Drives directed scenarios and a randomized symbol/slip/gap stream into the
// aligner and compares every cycle against a bit-history reference model.

module tb_serdes_rx_aligner;

  localparam logic [9:0] C_NEG = 10'h17C;
  localparam logic [9:0] C_POS = 10'h283;
  localparam logic [9:0] D215  = 10'h155;
  localparam int LOCK_N = 2;
  localparam int LOSS_N = 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       rx_in;
  logic [9:0] sym_out;
  logic       sym_valid;
  logic       comma_det;
  logic       locked;
  logic [1:0] state_o;

  always #5 clk = ~clk;

  serdes_rx_aligner #(
    .COMMA_NEG(C_NEG),
    .COMMA_POS(C_POS),
    .LOCK_COMMAS(LOCK_N),
    .LOSS_LIMIT(LOSS_N)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .rx_in(rx_in),
    .sym_out(sym_out),
    .sym_valid(sym_valid),
    .comma_det(comma_det),
    .locked(locked),
    .state_o(state_o)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_bad = 0;
  logic [9:0] exp_q[$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Mode: 0 hunting, 1 confirming, 2 locked. Boundary = multiple of 10
  // enabled bits since the last alignment point.
  bit         hist_q[$];
  int         m_mode;
  int         m_edges;
  int         m_align;
  int         m_good;
  int         m_bad;
  logic [9:0] e_sym;
  logic       e_valid;
  logic       e_comma;
  logic       e_locked;

  task automatic model_reset();
    hist_q.delete();
    for (int i = 0; i < 10; i++) hist_q.push_back(1'b0);
    m_mode = 0; m_edges = 0; m_align = 0; m_good = 0; m_bad = 0;
    e_sym = '0; e_valid = 1'b0; e_comma = 1'b0; e_locked = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_emit(input logic [9:0] w, input logic c);
    e_sym = w;
    e_valid = 1'b1;
    e_comma = c;
    exp_q.push_back(w);
  endtask

  task automatic model_step(input logic en, input logic b);
    logic [9:0] w;
    bit is_c;
    bit on_bnd;
    e_valid = 1'b0;
    e_comma = 1'b0;
    if (!en) return;
    m_edges++;
    hist_q.push_back(b);
    void'(hist_q.pop_front());
    for (int i = 0; i < 10; i++) w[i] = hist_q[i];
    is_c = (w == C_NEG) || (w == C_POS);
    on_bnd = ((m_edges - m_align) % 10) == 0;
    if (m_mode == 0) begin
      if (is_c) begin
        model_emit(w, 1'b1);
        m_align = m_edges; m_good = 1; m_bad = 0;
        if (LOCK_N == 1) begin m_mode = 2; e_locked = 1'b1; end
        else m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (is_c && !on_bnd) begin
        model_emit(w, 1'b1);
        m_align = m_edges; m_good = 1;
      end else if (on_bnd) begin
        model_emit(w, is_c);
        if (is_c) begin
          m_good++;
          if (m_good >= LOCK_N) begin m_mode = 2; e_locked = 1'b1; m_bad = 0; end
        end
      end
    end else begin
      if (is_c && !on_bnd) begin
        m_bad++;
        if (m_bad == LOSS_N) begin
          m_mode = 0; e_locked = 1'b0; m_bad = 0; m_good = 0;
        end
      end else if (on_bnd) begin
        model_emit(w, is_c);
        if (is_c) m_bad = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("sym_valid", {15'd0, sym_valid}, {15'd0, e_valid});
    check("comma_det", {15'd0, comma_det}, {15'd0, e_comma});
    check("locked", {15'd0, locked}, {15'd0, e_locked});
    check("state", {14'd0, state_o}, m_mode[15:0]);
    check("sym_out", {6'd0, sym_out}, {6'd0, e_sym});
    if (sym_valid) begin
      if (exp_q.size() == 0) check("sym_q_empty", 16'd1, 16'd0);
      else check("sym_q", {6'd0, sym_out}, {6'd0, exp_q.pop_front()});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic en, input logic b);
    @(negedge clk);
    enable = en;
    rx_in = b;
    @(posedge clk);
    model_step(en, b);
    #1;
    compare_all();
  endtask

  // Send a 10-bit symbol LSB first; gap_pct gives the chance of idle cycles before each bit.
  task automatic send_sym(input logic [9:0] s, input int gap_pct);
    for (int i = 0; i < 10; i++) begin
      while ($urandom_range(0, 99) < gap_pct) step(1'b0, 1'($urandom));
      step(1'b1, s[i]);
    end
  endtask

  task automatic send_bits(input logic [9:0] bits, input int n);
    for (int i = 0; i < n; i++) step(1'b1, bits[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    enable = 1'b0;
    rx_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    enable = 1'b0;
    rx_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_sym_out", {6'd0, sym_out}, 16'd0);
    check("rst_valid", {15'd0, sym_valid}, 16'd0);
    check("rst_state", {14'd0, state_o}, 16'd0);
    check("rst_locked", {15'd0, locked}, 16'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: junk 1,0,1 then two aligned RD- commas.
    send_bits(10'b101, 3);
    send_sym(C_NEG, 0);
    check("s1_first_sym", {6'd0, sym_out}, 16'h17C);
    check("s1_state_check", {14'd0, state_o}, 16'd1);
    send_sym(C_NEG, 0);
    check("s1_locked", {15'd0, locked}, 16'd1);
    check("s1_state_locked", {14'd0, state_o}, 16'd2);

    // 2: locked data stream.
    repeat (4) send_sym(D215, 0);
    check("s2_sym", {6'd0, sym_out}, 16'h155);
    check("s2_locked", {15'd0, locked}, 16'd1);

    // 3: one-bit slip, two misaligned RD+ commas, then reacquire.
    send_bits(10'b0, 1);
    send_sym(C_POS, 0);
    check("s3_still_locked", {15'd0, locked}, 16'd1);
    send_sym(C_POS, 0);
    check("s3_lost", {15'd0, locked}, 16'd0);
    check("s3_hunt", {14'd0, state_o}, 16'd0);
    send_sym(C_POS, 0);
    check("s3_reacq_sym", {6'd0, sym_out}, 16'h283);
    check("s3_reacq_state", {14'd0, state_o}, 16'd1);

    // 4: full lock sequence with random enable gaps.
    do_reset();
    send_bits(10'b101, 3);
    send_sym(C_NEG, 40);
    send_sym(C_NEG, 40);
    check("s4_locked", {15'd0, locked}, 16'd1);
    check("s4_sym", {6'd0, sym_out}, 16'h17C);

    // 5: comma 4 bits off-boundary while confirming.
    do_reset();
    send_sym(C_NEG, 0);
    send_bits(10'b0101, 4);
    send_sym(C_NEG, 0);
    check("s5_realign_state", {14'd0, state_o}, 16'd1);
    check("s5_not_locked", {15'd0, locked}, 16'd0);
    send_sym(C_NEG, 0);
    check("s5_locked", {15'd0, locked}, 16'd1);

    // 6: asynchronous reset mid-symbol while locked.
    send_bits(10'h155, 5);
    #2;
    reset = 1'b1;
    #1;
    check("s6_async_sym", {6'd0, sym_out}, 16'd0);
    check("s6_async_locked", {15'd0, locked}, 16'd0);
    check("s6_async_state", {14'd0, state_o}, 16'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    send_sym(C_POS, 0);
    send_sym(C_POS, 0);
    check("s6_relock", {15'd0, locked}, 16'd1);

    // Randomized mix of commas, data, slips and idle runs.
    for (int t = 0; t < 250; t++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2) send_sym(C_NEG, 5);
      else if (r < 4) send_sym(C_POS, 5);
      else if (r < 8) send_sym(10'($urandom), 5);
      else if (r == 8) send_bits(10'($urandom), $urandom_range(1, 9));
      else repeat ($urandom_range(1, 6)) step(1'b0, 1'($urandom));
    end

    step(1'b0, 1'b0);
    check("sym_q_drained", exp_q.size()[15:0], 16'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/serdes_rx_aligner.md
Name: serdes_rx_aligner

Overview:
Receive-side word aligner for the 8b/10b serial link. It consumes the serial bitstream one bit per enabled clock, hunts for the K28.5 comma to find the symbol boundary, and emits aligned 10-bit symbols with a one-cycle valid strobe. It also tracks lock status so a downstream 8b/10b decoder only receives boundary-correct symbols. Bit order: the first bit received maps to sym_out[0] (bit a).

Parameters:
COMMA_NEG, 10'h17C, K28.5 RD- in sym_out bit order (bit0 = first received)
COMMA_POS, 10'h283, K28.5 RD+ in sym_out bit order
LOCK_COMMAS, 2, consecutive aligned commas required to assert locked (range 1..7)
LOSS_LIMIT, 2, consecutive misaligned commas while locked that force re-hunt (range 1..7)

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
enable  input  1  bit strobe; rx_in is sampled only on clk edges with enable=1
rx_in  input  1  serial data, first-transmitted bit first
sym_out  output  10  aligned symbol, registered; holds its value between strobes
sym_valid  output  1  one-clk pulse; sym_out carries a new aligned symbol
comma_det  output  1  one-clk pulse, coincident with sym_valid, when sym_out is COMMA_NEG or COMMA_POS
locked  output  1  level; alignment is confirmed
state_o  output  2  debug: 0 HUNT, 1 CHECK, 2 LOCKED

Behaviour:
- Reset values: shift register 0, bit_cnt 0, good_cnt 0, bad_cnt 0, state HUNT, sym_out 0, sym_valid 0, comma_det 0, locked 0. An asserted reset mid-stream discards all partial data.
- Shift on each enabled edge: sr <= {rx_in, sr[9:1]}. Define win = {rx_in, sr[9:1]}, the next-window value. All comparisons use win combinationally, and all outputs are registered at that same edge.
- is_comma = (win == COMMA_NEG) || (win == COMMA_POS). Because the all-zero reset window never matches, no fill counter is needed.
- When enable=0: sr, counters, state and sym_out hold; sym_valid and comma_det are 0.
- sym_valid and comma_det are high for exactly one clk after the strobing edge and clear on the next edge regardless of enable.
- bit_cnt runs 0..9 and wraps, advancing only on enabled edges. A boundary is an enabled edge with bit_cnt==9.
- HUNT:
  - On is_comma: sym_out<=win, sym_valid=1, comma_det=1, bit_cnt<=0, good_cnt<=1.
  - Then go to LOCKED if LOCK_COMMAS==1, otherwise go to CHECK.
  - Otherwise no output.
- CHECK:
  - On a boundary: emit win (sym_valid=1). If is_comma, set comma_det=1 and increment good_cnt; when good_cnt reaches LOCK_COMMAS, go to LOCKED and set locked<=1.
  - On is_comma at a non-boundary edge: realign. Emit win as a comma, bit_cnt<=0, good_cnt<=1, stay in CHECK.
- LOCKED:
  - On a boundary: emit win. If is_comma, set comma_det=1 and bad_cnt<=0.
  - On is_comma at a non-boundary edge: bad_cnt+1 and no output. If bad_cnt+1 == LOSS_LIMIT, go to HUNT, locked<=0, bad_cnt<=0, good_cnt<=0.
  - Non-comma data never affects lock.
- Latency: the symbol whose last bit is sampled at edge N appears with sym_valid high in the cycle following edge N.
- Simultaneous events: the realign/loss rules take priority over the boundary emit when a comma is found off-boundary; only one action occurs per edge.

Test Plan:
1. Reset, then stream 3 junk bits 1,0,1 followed by COMMA_NEG (LSB first) and COMMA_NEG -> first sym_valid with sym_out=0x17C and comma_det=1, state CHECK; the second comma gives locked=1, state LOCKED.
2. Locked stream of D21.5 (0x155) x4 -> four sym_valid pulses spaced exactly 10 enabled edges apart, sym_out=0x155, comma_det=0, locked stays 1.
3. While locked, insert one extra bit, then COMMA_POS x2 (misaligned) -> bad_cnt reaches 2, locked drops, state HUNT; the following COMMA_POS re-acquires with sym_out=0x283.
4. enable toggled 1,0,0,1 with random gaps over a full lock sequence -> identical symbols to scenario 1; no sym_valid on any disabled cycle; each pulse lasts 1 clk.
5. In CHECK, a comma arrives 4 bits off-boundary -> immediate realign, good_cnt=1, locked stays 0 until the next aligned comma.
6. Assert reset while locked, mid-symbol -> all outputs 0 and state HUNT immediately (asynchronous); the stream resumes and locks after 2 commas.
